// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the multicycle MIPS datapath controls.
// Outputs decode from the state register and the opcode latched on leaving DECODE.
module multicycle_control #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       BranchEq,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ExtOp,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [3:0] state,
    output logic       retire,
    output logic       illegal
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RCOMP  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IEXEC  = 4'd10,
        ICOMP  = 4'd11,
        HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;

    state_t     st, nx;
    logic [5:0] op_q;
    logic       known;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st   <= FETCH;
            op_q <= 6'b000000;
        end else begin
            st <= nx;
            if (st == DECODE) op_q <= opcode;
        end
    end

    // The live opcode is consulted only while in DECODE, before op_q is loaded.
    assign known = opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI};

    always_comb begin
        nx = FETCH;
        case (st)
            FETCH:  nx = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     nx = MEMADR;
                    OP_R:             nx = EXEC;
                    OP_BEQ, OP_BNE:   nx = BRANCH;
                    OP_J:             nx = JUMP;
                    OP_ADDI, OP_ANDI: nx = IEXEC;
                    default:          nx = ILLEGAL_TRAP ? HALT : FETCH;
                endcase
            end
            MEMADR: nx = (op_q == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nx = MEMWB;
            EXEC:   nx = RCOMP;
            IEXEC:  nx = ICOMP;
            HALT:   nx = HALT;
            default: nx = FETCH;
        endcase
    end

    always_comb begin
        PCWrite  = 1'b0;
        BranchEq = 1'b0;
        BranchNe = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        IRWrite  = 1'b0;
        ALUSrcA  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        ExtOp    = 1'b1;
        PCSource = 2'b00;
        ALUSrcB  = 2'b00;
        ALUOp    = 3'b000;
        retire   = 1'b0;
        illegal  = 1'b0;
        case (st)
            FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                illegal = !known;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retire   = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
            end
            RCOMP: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 3'b001;
                PCSource = 2'b01;
                BranchEq = (op_q == OP_BEQ);
                BranchNe = (op_q == OP_BNE);
                retire   = 1'b1;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                retire   = 1'b1;
            end
            IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (op_q == OP_ANDI) ? 3'b100 : 3'b011;
                ExtOp   = (op_q != OP_ANDI);
            end
            ICOMP: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            HALT: illegal = 1'b1;
            default: ;
        endcase
        // Reset must silence strobes immediately, not just after the state register clears.
        if (reset) begin
            PCWrite  = 1'b0;
            BranchEq = 1'b0;
            BranchNe = 1'b0;
            IorD     = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            MemtoReg = 1'b0;
            IRWrite  = 1'b0;
            ALUSrcA  = 1'b0;
            RegWrite = 1'b0;
            RegDst   = 1'b0;
            ExtOp    = 1'b1;
            PCSource = 2'b00;
            ALUSrcB  = 2'b00;
            ALUOp    = 3'b000;
            retire   = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state = st;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multicycle control FSM,
// with a second instance built with ILLEGAL_TRAP = 1.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] opcode = 6'b000000;
    int tests = 0;
    int fails = 0;

    logic PCWrite, BranchEq, BranchNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic ALUSrcA, RegWrite, RegDst, ExtOp, retire, illegal;
    logic [1:0] PCSource, ALUSrcB;
    logic [2:0] ALUOp;
    logic [3:0] state;

    logic PCWrite_t, BranchEq_t, BranchNe_t, IorD_t, MemRead_t, MemWrite_t, MemtoReg_t, IRWrite_t;
    logic ALUSrcA_t, RegWrite_t, RegDst_t, ExtOp_t, retire_t, illegal_t;
    logic [1:0] PCSource_t, ALUSrcB_t;
    logic [2:0] ALUOp_t;
    logic [3:0] state_t;

    always #5 clk = ~clk;

    multicycle_control #(.ILLEGAL_TRAP(1'b0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .PCWrite(PCWrite), .BranchEq(BranchEq), .BranchNe(BranchNe), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
        .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst), .ExtOp(ExtOp),
        .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state(state),
        .retire(retire), .illegal(illegal)
    );

    multicycle_control #(.ILLEGAL_TRAP(1'b1)) dut_t (
        .clk(clk), .reset(reset), .opcode(opcode),
        .PCWrite(PCWrite_t), .BranchEq(BranchEq_t), .BranchNe(BranchNe_t), .IorD(IorD_t),
        .MemRead(MemRead_t), .MemWrite(MemWrite_t), .MemtoReg(MemtoReg_t), .IRWrite(IRWrite_t),
        .ALUSrcA(ALUSrcA_t), .RegWrite(RegWrite_t), .RegDst(RegDst_t), .ExtOp(ExtOp_t),
        .PCSource(PCSource_t), .ALUSrcB(ALUSrcB_t), .ALUOp(ALUOp_t), .state(state_t),
        .retire(retire_t), .illegal(illegal_t)
    );

    // Sampling point: 1 time unit after the falling edge, well clear of the rising edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] ctl;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        ctl = {PCWrite, BranchEq, BranchNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, ExtOp};
        tests++;
        if (ctl !== 12'h001) begin fails++; $display("FAIL reset_ctl got %h want 001", ctl); end
        tests++;
        if ({state, PCSource, ALUSrcB, ALUOp, retire, illegal} !== 13'd0) begin
            fails++;
            $display("FAIL reset_misc got state=%0d pcs=%b srcb=%b aluop=%b ret=%b ill=%b want all 0",
                     state, PCSource, ALUSrcB, ALUOp, retire, illegal);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if ({state, PCWrite, MemRead, IRWrite, IorD, ALUSrcA, ALUSrcB, ALUOp, PCSource} !== {4'd0, 3'b111, 2'b00, 2'b01, 3'b000, 2'b00}) begin
            fails++;
            $display("FAIL fetch_after_reset got state=%0d pcw=%b mr=%b irw=%b srcb=%b want 0 1 1 1 01",
                     state, PCWrite, MemRead, IRWrite, ALUSrcB);
        end
    endtask

    task automatic test_lw();
        int seq[6] = '{0, 1, 2, 3, 4, 0};
        opcode = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (state !== 4'(seq[i]) || MemRead !== (seq[i] == 0 || seq[i] == 3) ||
                RegWrite !== (seq[i] == 4) || retire !== (seq[i] == 4)) begin
                fails++;
                $display("FAIL lw_cycle%0d got state=%0d mr=%b rw=%b ret=%b want state=%0d",
                         i, state, MemRead, RegWrite, retire, seq[i]);
            end
            if (seq[i] == 1) begin
                tests++;
                if (ALUSrcB !== 2'b11 || ALUSrcA !== 1'b0 || PCWrite !== 1'b0) begin
                    fails++;
                    $display("FAIL decode_ctl got srcb=%b srca=%b pcw=%b want 11 0 0", ALUSrcB, ALUSrcA, PCWrite);
                end
            end
            if (seq[i] == 2) begin
                tests++;
                if (ALUSrcB !== 2'b10 || ALUSrcA !== 1'b1 || ALUOp !== 3'b000) begin
                    fails++;
                    $display("FAIL memadr_ctl got srcb=%b srca=%b aluop=%b want 10 1 000", ALUSrcB, ALUSrcA, ALUOp);
                end
            end
            if (seq[i] == 4) begin
                tests++;
                if (MemtoReg !== 1'b1 || RegDst !== 1'b0) begin
                    fails++;
                    $display("FAIL memwb_ctl got m2r=%b rd=%b want 1 0", MemtoReg, RegDst);
                end
            end
            if (i < 5) step();
        end
    endtask

    task automatic test_bne();
        int seq[4] = '{0, 1, 8, 0};
        opcode = 6'b000101;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (state !== 4'(seq[i])) begin
                fails++;
                $display("FAIL bne_seq%0d got %0d want %0d", i, state, seq[i]);
            end
            if (seq[i] == 8) begin
                tests++;
                if ({BranchNe, BranchEq, ALUOp, PCSource, retire, ALUSrcA} !== {1'b1, 1'b0, 3'b001, 2'b01, 1'b1, 1'b1}) begin
                    fails++;
                    $display("FAIL bne_branch got bne=%b beq=%b aluop=%b pcs=%b ret=%b want 1 0 001 01 1",
                             BranchNe, BranchEq, ALUOp, PCSource, retire);
                end
            end
            if (i < 3) step();
        end
    endtask

    task automatic test_beq();
        opcode = 6'b000100;
        step();
        step();
        tests++;
        if ({state, BranchEq, BranchNe} !== {4'd8, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL beq_branch got state=%0d beq=%b bne=%b want 8 1 0", state, BranchEq, BranchNe);
        end
        step();
    endtask

    task automatic test_imm(input logic [5:0] op, input logic [2:0] aluop, input logic ext);
        int seq[5] = '{0, 1, 10, 11, 0};
        opcode = op;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (state !== 4'(seq[i])) begin
                fails++;
                $display("FAIL imm%b_seq%0d got %0d want %0d", op, i, state, seq[i]);
            end
            if (seq[i] == 10) begin
                tests++;
                if ({ALUOp, ExtOp, ALUSrcA, ALUSrcB} !== {aluop, ext, 1'b1, 2'b10}) begin
                    fails++;
                    $display("FAIL iexec_%b got aluop=%b ext=%b srcb=%b want %b %b 10",
                             op, ALUOp, ExtOp, ALUSrcB, aluop, ext);
                end
            end
            if (seq[i] == 11) begin
                tests++;
                if ({RegWrite, RegDst, MemtoReg, retire} !== 4'b1001) begin
                    fails++;
                    $display("FAIL icomp_%b got rw=%b rd=%b m2r=%b ret=%b want 1 0 0 1",
                             op, RegWrite, RegDst, MemtoReg, retire);
                end
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_jump();
        opcode = 6'b000010;
        step();
        step();
        tests++;
        if ({state, PCWrite, PCSource, retire} !== {4'd9, 1'b1, 2'b10, 1'b1}) begin
            fails++;
            $display("FAIL jump got state=%0d pcw=%b pcs=%b ret=%b want 9 1 10 1", state, PCWrite, PCSource, retire);
        end
        step();
        tests++;
        if (state !== 4'd0) begin fails++; $display("FAIL jump_return got %0d want 0", state); end
    endtask

    task automatic test_rtype_toggle();
        opcode = 6'b000000;
        step();
        step();
        tests++;
        if ({state, ALUOp, ALUSrcA, ALUSrcB} !== {4'd6, 3'b010, 1'b1, 2'b00}) begin
            fails++;
            $display("FAIL exec got state=%0d aluop=%b srca=%b srcb=%b want 6 010 1 00", state, ALUOp, ALUSrcA, ALUSrcB);
        end
        opcode = 6'b100011;
        step();
        tests++;
        if ({state, RegDst, RegWrite, MemtoReg} !== {4'd7, 3'b110}) begin
            fails++;
            $display("FAIL rcomp got state=%0d rd=%b rw=%b m2r=%b want 7 1 1 0", state, RegDst, RegWrite, MemtoReg);
        end
        step();
        tests++;
        if (state !== 4'd0) begin fails++; $display("FAIL rtype_return got %0d want 0", state); end
    endtask

    task automatic test_illegal();
        do_reset();
        opcode = 6'b111111;
        step();
        tests++;
        if ({state, illegal, state_t, illegal_t} !== {4'd1, 1'b1, 4'd1, 1'b1}) begin
            fails++;
            $display("FAIL illegal_decode got st=%0d ill=%b st_t=%0d ill_t=%b want 1 1 1 1",
                     state, illegal, state_t, illegal_t);
        end
        step();
        tests++;
        if ({state, illegal, MemWrite, RegWrite} !== {4'd0, 3'b000}) begin
            fails++;
            $display("FAIL illegal_notrap got st=%0d ill=%b mw=%b rw=%b want 0 0 0 0", state, illegal, MemWrite, RegWrite);
        end
        for (int i = 0; i < 20; i++) begin
            tests++;
            if ({state_t, illegal_t, MemWrite_t, RegWrite_t, PCWrite_t, IRWrite_t} !== {4'd15, 5'b10000}) begin
                fails++;
                $display("FAIL halt_hold%0d got st=%0d ill=%b mw=%b rw=%b pcw=%b want 15 1 0 0 0",
                         i, state_t, illegal_t, MemWrite_t, RegWrite_t, PCWrite_t);
            end
            step();
        end
        opcode = 6'b000000;
        do_reset();
        tests++;
        if ({state_t, illegal_t, PCWrite_t} !== {4'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL halt_reset got st=%0d ill=%b pcw=%b want 0 0 1", state_t, illegal_t, PCWrite_t);
        end
    endtask

    task automatic test_sw_reset();
        opcode = 6'b101011;
        step();
        step();
        step();
        tests++;
        if ({state, MemWrite, IorD, retire} !== {4'd5, 3'b111}) begin
            fails++;
            $display("FAIL memwr got st=%0d mw=%b iord=%b ret=%b want 5 1 1 1", state, MemWrite, IorD, retire);
        end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if ({MemWrite, state, ExtOp, IorD} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL sw_abort got mw=%b st=%0d ext=%b want 0 0 1", MemWrite, state, ExtOp);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if ({state, PCWrite, IRWrite} !== {4'd0, 2'b11}) begin
            fails++;
            $display("FAIL sw_release got st=%0d pcw=%b irw=%b want 0 1 1", state, PCWrite, IRWrite);
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_lw();
        test_bne();
        test_beq();
        test_imm(6'b001100, 3'b100, 1'b0);
        test_imm(6'b001000, 3'b011, 1'b1);
        test_jump();
        test_rtype_toggle();
        test_sw_reset();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
